inst_loader: RTL and testbench

Program loader that writes the instruction memory. It takes a byte stream (valid/ready handshake), assembles little-endian 32-bit instruction words and writes them to consecutive word addresses starting at 0. While a load runs it holds the CPU in stall so fetch never reads a partially written program. The loader sits between the debug/UART byte source and the write port of a writable instruction memory.

---
 rtl/inst_loader.sv | 174 +++++++++++++++++
 tb/tb_inst_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// inst_loader: program loader for the writable instruction memory.
//
// Accepts a byte stream (byte_valid/byte_ready), assembles little-endian
// 32-bit words and writes them to word addresses 0..len-1. The CPU is held
// in stall (cpu_hold) for the whole load so fetch never sees a partial program.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, load_len     one-cycle start pulse and word count (sampled when idle)
//   byte_valid/data     incoming program bytes, byte 0 of each word first
//   byte_ready          loader accepts a byte this cycle
//   mem_we/addr/wdata   instruction memory write port (one pulse per word)
//   cpu_hold, busy      stall request / load in progress
//   done                one-cycle pulse at end of load
//   err                 sticky error, cleared by the next accepted start
//
// Build option: define CHECKSUM_EN to require one trailing byte equal to the
// XOR of all data bytes; a mismatch sets err (written words are kept).

module inst_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len;
    logic [ADDR_W-1:0] word_cnt;
    logic [ADDR_W-1:0] word_nxt;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;      // bytes 0..2 of the word being received
    logic              too_long;
`ifdef CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign too_long = {1'b0, load_len} > DEPTH_L;
    assign word_nxt = word_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        cpu_hold   = 1'b0;
        mem_we     = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !too_long)
                    state_nxt = (load_len == '0) ? S_DONE : S_RECV;
            end
            S_RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                cpu_hold = 1'b1;
                mem_we   = 1'b1;
                if (word_nxt == len) begin
`ifdef CHECKSUM_EN
                    state_nxt = S_CSUM;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    state_nxt = S_RECV;
                end
            end
`ifdef CHECKSUM_EN
            S_CSUM: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
                if (byte_valid) state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // mem_addr/mem_wdata are loaded on the 4th byte so they are valid during
    // WRITE and hold that value afterwards; only mem_we qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            shift     <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len      <= load_len;
                        err      <= too_long;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        shift    <= '0;
`ifdef CHECKSUM_EN
                        csum     <= '0;
`endif
                    end
                end
                S_RECV: begin
                    if (byte_valid) begin
                        shift    <= {byte_data, shift[23:8]};
                        byte_cnt <= byte_cnt + 1'b1;
`ifdef CHECKSUM_EN
                        csum     <= csum ^ byte_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_addr  <= word_cnt;
                            mem_wdata <= {byte_data, shift};
                        end
                    end
                end
                S_WRITE: begin
                    word_cnt <= word_nxt;
                    byte_cnt <= '0;
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (byte_valid && byte_data != csum) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
module tb_inst_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] load_len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    inst_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Monitor state (written only by the monitor process).
    logic [39:0] got[$];
    int unsigned cyc = 0, we_cyc = 0, done_cyc = 0;
    int unsigned done_cnt = 0, acc_cnt = 0, ready_we_bad = 0, hold_bad = 0;

    logic [31:0] wbuf[0:DEPTH-1];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_we) begin
                got.push_back({mem_addr, mem_wdata});
                we_cyc = cyc;
                if (byte_ready) ready_we_bad++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (cpu_hold) hold_bad++;
            end
            if (byte_valid && byte_ready) acc_cnt++;
            if (busy !== cpu_hold) hold_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        do begin
            @(negedge clk);
            n++;
        end while (byte_ready !== 1'b1 && n < 50);
        if (byte_ready !== 1'b1) chk("byte_ready_timeout", {63'b0, byte_ready}, 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    // Reference: word i of the load lands at address i; done pulses once
    // unless len exceeds DEPTH; err follows len > DEPTH or a bad checksum.
    task automatic run_load(input int unsigned len, input int unsigned gap,
                            input bit mid_start, input bit bad_csum);
        int unsigned g0 = got.size();
        int unsigned d0 = done_cnt;
        int unsigned a0 = acc_cnt;
        int unsigned exp_bytes;
        logic [7:0] cs = 8'h00;
        logic [31:0] w;
        bit exp_err;

        start    = 1'b1;
        load_len = ADDR_W'(len);
        @(posedge clk);
        #1;
        start    = 1'b0;
        load_len = '0;

        if (len > DEPTH) begin
            chk("err_on_overlength", {63'b0, err}, 64'd1);
            chk("busy_after_overlength", {63'b0, busy}, 64'd0);
            repeat (8) @(posedge clk);
            #1;
            chk("no_done_overlength", 64'(done_cnt - d0), 64'd0);
            chk("no_write_overlength", 64'(got.size() - g0), 64'd0);
            return;
        end

        if (len == 0) chk("done_after_len0", {63'b0, done}, 64'd1);

        for (int i = 0; i < int'(len); i++) begin
            for (int k = 0; k < 4; k++) begin
                if (gap > 0) begin
                    repeat (gap) @(posedge clk);
                    #1;
                end
                if (mid_start && i == int'(len / 2) && k == 1) begin
                    start    = 1'b1;
                    load_len = ADDR_W'(len + 1);
                    @(posedge clk);
                    #1;
                    start    = 1'b0;
                    load_len = '0;
                end
                w = wbuf[i] >> (8 * k);
                cs ^= w[7:0];
                send_byte(w[7:0]);
            end
        end
        exp_bytes = 4 * len;
        exp_err   = 1'b0;
`ifdef CHECKSUM_EN
        if (len > 0) begin
            send_byte(bad_csum ? (cs ^ 8'h5a) : cs);
            exp_bytes++;
            exp_err = bad_csum;
        end
`endif

        for (int n = 0; n < 40; n++) begin
            if (done_cnt != d0) break;
            @(posedge clk);
            #1;
        end
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("write_count", 64'(got.size() - g0), 64'(len));
        for (int i = 0; i < int'(len) && g0 + i < got.size(); i++)
            chk($sformatf("write[%0d]", i), 64'(got[g0 + i]), {24'b0, 8'(i), wbuf[i]});
        chk("bytes_accepted", 64'(acc_cnt - a0), 64'(exp_bytes));
        chk("err_after_load", {63'b0, err}, {63'b0, exp_err});
`ifndef CHECKSUM_EN
        if (len > 0) chk("done_follows_write", 64'(done_cyc - we_cyc), 64'd1);
`endif
        chk("busy_after_done", {63'b0, busy}, 64'd0);
        if (bad_csum) ;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_ready"}, {63'b0, byte_ready}, 64'd0);
        chk({tag, "_we"},    {63'b0, mem_we},     64'd0);
        chk({tag, "_addr"},  64'(mem_addr),       64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata),      64'd0);
        chk({tag, "_hold"},  {63'b0, cpu_hold},   64'd0);
        chk({tag, "_busy"},  {63'b0, busy},       64'd0);
        chk({tag, "_done"},  {63'b0, done},       64'd0);
        chk({tag, "_err"},   {63'b0, err},        64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word.
        wbuf[0] = 32'h00002083;
        run_load(1, 0, 1'b0, 1'b0);

        // Three words.
        wbuf[0] = 32'h00002083; wbuf[1] = 32'h00402103; wbuf[2] = 32'h000001b3;
        run_load(3, 0, 1'b0, 1'b0);

        // Zero length, then over-length, then a valid start clears err.
        run_load(0, 0, 1'b0, 1'b0);
        run_load(65, 0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
        run_load(2, 1, 1'b0, 1'b0);

        // Stalled source with an ignored start mid-load.
        for (int i = 0; i < 4; i++) wbuf[i] = $urandom;
        run_load(4, 3, 1'b1, 1'b0);

        // Reset mid-operation: one full word, then 2 bytes of word 1.
        start = 1'b1; load_len = 8'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) send_byte(8'(8'h11 * (k + 1)));
        rst = 1'b1;
        #1;
        chk_idle_outputs("midreset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        wbuf[0] = 32'hfe000ae3;
        run_load(1, 0, 1'b0, 1'b0);

        // Randomized loads, including a full-depth load.
        for (int t = 0; t < 5; t++) begin
            int unsigned n = $urandom_range(1, 8);
            for (int i = 0; i < int'(n); i++) wbuf[i] = $urandom;
            run_load(n, $urandom_range(0, 2), 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) wbuf[i] = $urandom;
        run_load(DEPTH, 0, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
        wbuf[0] = 32'h00002083;
        run_load(1, 0, 1'b0, 1'b0);
        run_load(1, 0, 1'b0, 1'b1);
`endif

        chk("byte_ready_during_write", 64'(ready_we_bad), 64'd0);
        chk("hold_tracks_busy", 64'(hold_bad), 64'd0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
